modexp_sequencer: RTL and testbench

//  Left-to-right square-and-multiply controller computing O = A^E mod N for the RSA path.

---
 rtl/modexp_pkg.sv | 24 ++
 rtl/modexp_sequencer_if.sv | 31 +++
 rtl/modexp_sequencer.sv | 156 +++++++++++++++
 tb/tb_modexp_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// modexp_pkg: shared definitions for the modular-exponentiation sequencer.
//   WIDTH_DEF / EXP_WIDTH_DEF : default operand and exponent widths
//   S_*                       : FSM state encodings
//   op_t                      : multiply kind, selects the successor once WAIT completes
package modexp_pkg;

  localparam int WIDTH_DEF     = 64;
  localparam int EXP_WIDTH_DEF = 64;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_SQR    = 3'd3;
  localparam logic [2:0] S_MUL    = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  typedef enum logic [1:0] {
    OP_REDUCE = 2'd0,
    OP_SQR    = 2'd1,
    OP_MUL    = 2'd2
  } op_t;

endpackage

// File: rtl/modexp_sequencer_if.sv
// modexp_sequencer_if: bus between the sequencer and the shared modular multiplier.
//   mul_start   : 1-cycle pulse issuing P = X*Y mod N
//   mul_x/mul_y : operands, held from mul_start until mul_done
//   mul_n       : modulus, held for the whole exponentiation
//   mul_done    : 1-cycle pulse, mul_p valid
//   mul_p       : product X*Y mod N
// master = sequencer side, slave = multiplier side.
interface modexp_sequencer_if
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             mul_start;
  logic [WIDTH-1:0] mul_x;
  logic [WIDTH-1:0] mul_y;
  logic [WIDTH-1:0] mul_n;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  modport master (
    output mul_start, mul_x, mul_y, mul_n,
    input  mul_done, mul_p
  );

  modport slave (
    input  mul_start, mul_x, mul_y, mul_n,
    output mul_done, mul_p
  );

endinterface

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: left-to-right square-and-multiply controller, O = A^E mod N.
// Owns no arithmetic; drives one external modular multiplier through the mul bus.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start               : 1-cycle request, honoured only in IDLE and not while done pulses
//   base/exponent/modulus : A, E, N, captured on an accepted start
//   busy                : cycle after accepted start through the done pulse inclusive
//   done                : 1-cycle pulse, result/err valid
//   err                 : 1 when N was 0
//   result              : A^E mod N, held until the next accepted start
//   mul                 : multiplier bus (master side)
//
// state  | meaning
// IDLE   | waiting for start
// SCAN   | skipping leading zero exponent bits, one per cycle
// REDUCE | issue A*1 mod N to get the reduced base
// SQR    | issue acc*acc
// MUL    | issue acc*base_red
// WAIT   | operands held until mul_done; ret_op picks the successor
// FIN    | latch result, pulse done
module modexp_sequencer
  import modexp_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  modexp_sequencer_if.master   mul
);

  localparam int              IW    = $clog2(EXP_WIDTH);
  localparam logic [IW-1:0]   I_TOP = IW'(EXP_WIDTH - 1);

  logic [2:0]           state;
  logic [WIDTH-1:0]     a_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [WIDTH-1:0]     base_red;
  logic [WIDTH-1:0]     acc;
  logic [IW-1:0]        bit_idx;
  op_t                  ret_op;
  logic                 err_flag;
  logic                 last_bit;

  assign last_bit = (bit_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      a_reg         <= '0;
      e_reg         <= '0;
      base_red      <= '0;
      acc           <= '0;
      bit_idx       <= '0;
      ret_op        <= OP_REDUCE;
      err_flag      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      result        <= '0;
      mul.mul_start <= 1'b0;
      mul.mul_x     <= '0;
      mul.mul_y     <= '0;
      mul.mul_n     <= '0;
    end else begin
      done          <= 1'b0;
      mul.mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped
          if (start && !done) begin
            a_reg     <= base;
            e_reg     <= exponent;
            mul.mul_n <= modulus;
            bit_idx   <= I_TOP;
            acc       <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            if (modulus == '0) begin
              err_flag <= 1'b1;
              state    <= S_FIN;
            end else begin
              err_flag <= 1'b0;
              state    <= S_SCAN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_SCAN: begin
          if (e_reg[bit_idx]) begin
            state <= S_REDUCE;
          end else if (!last_bit) begin
            bit_idx <= bit_idx - 1'b1;
          end else begin
            // E == 0: A^0 = 1, which reduces to 0 when N == 1
            acc   <= (mul.mul_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            state <= S_FIN;
          end
        end
        S_REDUCE: begin
          mul.mul_start <= 1'b1;
          mul.mul_x     <= a_reg;
          mul.mul_y     <= WIDTH'(1);
          ret_op        <= OP_REDUCE;
          state         <= S_WAIT;
        end
        S_SQR: begin
          mul.mul_start <= 1'b1;
          mul.mul_x     <= acc;
          mul.mul_y     <= acc;
          ret_op        <= OP_SQR;
          state         <= S_WAIT;
        end
        S_MUL: begin
          mul.mul_start <= 1'b1;
          mul.mul_x     <= acc;
          mul.mul_y     <= base_red;
          ret_op        <= OP_MUL;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (mul.mul_done) begin
            acc <= mul.mul_p;
            if (ret_op == OP_REDUCE) base_red <= mul.mul_p;
            // after a squaring, the current bit (already indexed) decides the multiply
            if (ret_op == OP_SQR && e_reg[bit_idx]) begin
              state <= S_MUL;
            end else if (last_bit) begin
              state <= S_FIN;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= S_SQR;
            end
          end
        end
        S_FIN: begin
          result <= acc;
          err    <= err_flag;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed bench for modexp_sequencer with a behavioural
// modular multiplier of programmable latency that also flags handshake abuse.
module tb_modexp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base = '0;
  logic [63:0] exponent = '0;
  logic [63:0] modulus = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;

  modexp_sequencer_if #(.WIDTH(64)) mif ();

  modexp_sequencer #(.WIDTH(64), .EXP_WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mul      (mif)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] n);
    logic [127:0] p;
    if (n == 64'd0) return 64'd0;
    p = {64'd0, x} * {64'd0, y};
    return 64'(p % {64'd0, n});
  endfunction

  // right-to-left reference, independent of the left-to-right order in the DUT
  function automatic logic [63:0] ref_modexp(input logic [63:0] a, input logic [63:0] e,
                                             input logic [63:0] n);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1 % n;
    b = a % n;
    for (int k = 0; k < 64; k++) begin
      if (e[k]) r = mulmod(r, b, n);
      b = mulmod(b, b, n);
    end
    return r;
  endfunction

  // behavioural multiplier
  int unsigned op_total = 0;
  int unsigned proto_bad = 0;
  int          mul_lat = 3;
  int          cnt;
  logic        pend;
  logic        mdl_done;
  logic        inj_done = 1'b0;
  logic [63:0] mdl_p;
  logic [63:0] cap_x;
  logic [63:0] cap_y;
  logic [63:0] cur_n = '0;

  assign mif.mul_done = mdl_done | inj_done;
  assign mif.mul_p    = inj_done ? 64'hdead_beef_0bad_f00d : mdl_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_done <= 1'b0;
      pend     <= 1'b0;
      cnt      <= 0;
      mdl_p    <= '0;
      cap_x    <= '0;
      cap_y    <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (mif.mul_start) begin
        op_total <= op_total + 1;
        if (pend || mif.mul_n !== cur_n) proto_bad <= proto_bad + 1;
        pend  <= 1'b1;
        cnt   <= mul_lat;
        cap_x <= mif.mul_x;
        cap_y <= mif.mul_y;
      end else if (pend) begin
        if (mif.mul_x !== cap_x || mif.mul_y !== cap_y) proto_bad <= proto_bad + 1;
        if (cnt <= 1) begin
          mdl_done <= 1'b1;
          pend     <= 1'b0;
          mdl_p    <= mulmod(cap_x, cap_y, cur_n);
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] n, input bit hammer, input logic [63:0] exp_res,
                        input logic exp_err, input int exp_ops);
    int unsigned ops0;
    bit got;
    ops0 = op_total;
    @(negedge clk);
    base = a; exponent = e; modulus = n; cur_n = n; start = 1'b1;
    @(negedge clk);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    start = hammer;
    got = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (hammer) begin
          base = {$urandom, $urandom};
          exponent = {$urandom, $urandom};
          modulus = {$urandom, $urandom};
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_ops"}, 64'(op_total - ops0), 64'(exp_ops));
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int unsigned ops0;
    bit got;
    logic [63:0] e63;
    e63 = 64'h8000_0000_0000_0000;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_mul_start", 64'(mif.mul_start), 64'd0);
    check("rst_mul_x", mif.mul_x, 64'd0);
    check("rst_mul_y", mif.mul_y, 64'd0);
    check("rst_mul_n", mif.mul_n, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("e13", 64'd4, 64'd13, 64'd497, 1'b0, 64'd445, 1'b0, 6);
    run_op("e0_n13", 64'd7, 64'd0, 64'd13, 1'b0, 64'd1, 1'b0, 0);
    run_op("e0_n1", 64'd7, 64'd0, 64'd1, 1'b0, 64'd0, 1'b0, 0);
    run_op("n0", 64'd5, 64'd3, 64'd0, 1'b0, 64'd0, 1'b1, 0);
    run_op("e1", 64'd1234567, 64'd1, 64'd1000, 1'b0, 64'd567, 1'b0, 1);
    run_op("e_msb", 64'd2, e63, 64'd1000003, 1'b0,
           ref_modexp(64'd2, e63, 64'd1000003), 1'b0, 64);
    run_op("hammer", 64'd4, 64'd13, 64'd497, 1'b1, 64'd445, 1'b0, 6);

    // stray mul_done pulses while the DUT is still scanning leading zeros
    fork
      run_op("stray_done", 64'd3, 64'd32, 64'd1000, 1'b0, 64'd841, 1'b0, 6);
      begin
        repeat (5) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (8) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
      end
    join

    // reset while a multiply is outstanding
    mul_lat = 30;
    @(negedge clk);
    base = 64'd4; exponent = 64'd13; modulus = 64'd497; cur_n = 64'd497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ops0 = op_total;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (mif.mul_start) got = 1'b1;
      else @(negedge clk);
    end
    check("rst_wait_reached", 64'(got), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_mul_start", 64'(mif.mul_start), 64'd0);
    check("mid_rst_mul_x", mif.mul_x, 64'd0);
    check("mid_rst_mul_y", mif.mul_y, 64'd0);
    check("mid_rst_mul_n", mif.mul_n, 64'd0);
    @(negedge clk);
    check("mid_rst_ops", 64'(op_total - ops0), 64'd0);
    rst = 1'b0;
    mul_lat = 3;
    @(negedge clk);
    run_op("post_rst", 64'd4, 64'd13, 64'd497, 1'b0, 64'd445, 1'b0, 6);

    check("handshake_protocol", 64'(proto_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
